// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction-fetch front end.
//
// Issues word-aligned fetch requests to a variable-latency instruction memory
// (req/gnt handshake, responses return in request order on rvalid) and keeps
// the returned words, tagged with their PC, in a DEPTH-entry FIFO. Decode
// pulls {instr, pc} from the FIFO head over a valid/ready handshake. A
// redirect reloads the fetch PC, empties the FIFO and squashes every response
// still in flight.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   redirect_i, redirect_pc_i    taken branch/jump and its target
//   imem_req_o, imem_addr_o      fetch request and word address
//   imem_gnt_i                   request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  in-order response and instruction word
//   instr_valid_o, instr_ready_i head handshake towards decode
//   instr_o, pc_o, pc_plus4_o    head instruction, its PC and PC+4
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  // Counters hold 0..DEPTH; pointers index 0..DEPTH-1 and wrap naturally.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [31:0]     r_instr_q [DEPTH];
  logic [XLEN-1:0] r_pc_q    [DEPTH];

  logic            w_credit_ok;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;
  logic [CW-1:0]   w_outst_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_rsp_cnt;

  // Credit: buffered plus in-flight words never exceed the FIFO size, so a
  // returning response always has a free slot.
  assign w_credit_ok   = ({1'b0, r_count} + {1'b0, r_outst}) < LIMIT;
  assign imem_req_o    = !rst_i && !redirect_i && w_credit_ok;
  assign imem_addr_o   = r_fetch_pc;
  assign w_gnt         = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding is ignored so the counters cannot
  // underflow.
  assign w_rsp         = imem_rvalid_i && (r_outst != '0);
  assign w_rsp_cnt     = {{(CW-1){1'b0}}, w_rsp};
  // A response arriving in a redirect cycle belongs to the old stream.
  assign w_push        = w_rsp && (r_discard == '0) && !redirect_i;
  assign w_drop        = w_rsp && (r_discard != '0) && !redirect_i;

  assign instr_valid_o = !rst_i && !redirect_i && (r_count != '0);
  assign w_pop         = instr_valid_o && instr_ready_i;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);

  assign instr_o       = r_instr_q[r_rptr];
  assign pc_o          = r_pc_q[r_rptr];
  assign pc_plus4_o    = pc_o + XLEN'(4);

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_gnt) w_outst_nxt = w_outst_nxt + CW'(1);
    if (w_rsp) w_outst_nxt = w_outst_nxt - CW'(1);
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push) w_count_nxt = w_count_nxt + CW'(1);
    if (w_pop)  w_count_nxt = w_count_nxt - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        // Recomputed from scratch, so a redirect during an earlier squash
        // does not count the same response twice.
        r_discard  <= r_outst - w_rsp_cnt;
      end else begin
        r_count <= w_count_nxt;
        if (w_gnt)  r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_wptr    <= r_wptr + AW'(1);
        end
        if (w_pop)  r_rptr    <= r_rptr + AW'(1);
        if (w_drop) r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Storage is not reset; entries are only observed once count says so.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_instr_q[r_wptr] <= imem_rdata_i;
      r_pc_q[r_wptr]    <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Contains an in-order instruction-memory model with random grant/latency,
// a stream-level reference model (expected fetch address, expected next PC,
// buffered/in-flight word counts tagged by redirect epoch), directed
// scenarios with literal expectations and a long randomized run.
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mem_t;

  mem_t        memq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          rst_w = 1'b1;
  int          p_gnt, p_rv, p_rdy, p_redir, lat_lo, lat_hi;
  logic [31:0] exp_fetch, exp_pc;
  int          buffered = 0;
  int unsigned epoch = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic bit pct(input int p);
    return (p >= 100) || (int'($urandom_range(0, 99)) < p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus: inputs change 1 time unit after the edge.
  task automatic step(input bit redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    rst_i      = rst_w;
    redirect_i = redir || (!rst_w && p_redir > 0 && pct(p_redir));
    redirect_pc_i = redir ? tgt : $urandom;
    imem_gnt_i    = pct(p_gnt);
    instr_ready_i = pct(p_rdy);
    if (!rst_w && memq.size() > 0 && memq[0].due <= cyc && pct(p_rv)) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_of(memq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_w = 1'b1;
    step(1'b0, 32'h0);
    chk_b("req_in_reset", imem_req_o, 1'b0);
    step(1'b1, 32'h40);
    chk_b("valid_in_reset_with_redirect", instr_valid_o, 1'b0);
    step(1'b0, 32'h0);
    rst_w = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid_o && n < 30) begin
      step(1'b0, 32'h0);
      n++;
    end
    if (!instr_valid_o) chk_b({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin : model
    bit   e_req;
    bit   e_valid;
    mem_t e;
    if (rst_i) begin
      chk_b("model_req_rst", imem_req_o, 1'b0);
      chk_b("model_valid_rst", instr_valid_o, 1'b0);
      memq.delete();
      buffered  = 0;
      exp_fetch = RESET_PC;
      exp_pc    = RESET_PC;
      epoch++;
    end else begin
      e_req   = !redirect_i && (memq.size() + buffered < DEPTH);
      e_valid = !redirect_i && (buffered != 0);
      chk_b("model_req", imem_req_o, e_req);
      if (imem_req_o) chk("model_addr", imem_addr_o, exp_fetch);
      chk_b("model_valid", instr_valid_o, e_valid);
      if (e_valid) begin
        chk("model_pc", pc_o, exp_pc);
        chk("model_instr", instr_o, word_of(exp_pc));
        chk("model_pc_plus4", pc_plus4_o, exp_pc + 32'd4);
      end
      if (imem_rvalid_i) begin
        chk_b("rvalid_with_request_in_flight", memq.size() != 0, 1'b1);
        if (memq.size() != 0) begin
          e = memq.pop_front();
          if (!redirect_i && e.epoch == epoch) buffered++;
        end
      end
      if (e_valid && instr_ready_i) begin
        buffered--;
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_req_o && imem_gnt_i) begin
        e.addr  = imem_addr_o;
        e.epoch = epoch;
        e.due   = cyc + $urandom_range(lat_lo, lat_hi);
        memq.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_i) begin
        epoch++;
        buffered  = 0;
        exp_fetch = redirect_pc_i & ~32'd3;
        exp_pc    = redirect_pc_i & ~32'd3;
      end
    end
  end

  initial begin
    int grants;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
    p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;

    // Zero-wait memory, decode always ready.
    do_reset();
    step(1'b0, 32'h0);
    chk_b("a_req_first", imem_req_o, 1'b1);
    chk("a_addr_first", imem_addr_o, 32'h0);
    chk_b("a_valid_first", instr_valid_o, 1'b0);
    step(1'b0, 32'h0);
    chk("a_addr_second", imem_addr_o, 32'h4);
    chk_b("a_rvalid_second", imem_rvalid_i, 1'b1);
    chk_b("a_valid_second", instr_valid_o, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 32'h0);
      chk_b("a_valid_stream", instr_valid_o, 1'b1);
      chk("a_pc_stream", pc_o, 32'(4 * k));
      chk("a_instr_stream", instr_o, word_of(32'(4 * k)));
    end

    // Decode stalled: only DEPTH requests may be outstanding or buffered.
    p_rdy = 0;
    do_reset();
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 32'h0);
      if (imem_req_o && imem_gnt_i) grants++;
    end
    chk("b_grants_when_stalled", 32'(grants), 32'd4);
    chk_b("b_req_when_full", imem_req_o, 1'b0);
    chk_b("b_valid_when_full", instr_valid_o, 1'b1);
    p_rdy = 100;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0);
      chk_b("b_valid_drain", instr_valid_o, 1'b1);
      chk("b_pc_drain", pc_o, 32'(4 * k));
      chk("b_instr_drain", instr_o, word_of(32'(4 * k)));
    end

    // Three requests in flight, then redirect to an unaligned target.
    do_reset();
    lat_lo = 3; lat_hi = 3; p_rv = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0);
      chk_b("c_req_fill", imem_req_o, 1'b1);
    end
    step(1'b1, 32'h103);
    chk_b("c_req_in_redirect", imem_req_o, 1'b0);
    chk_b("c_valid_in_redirect", instr_valid_o, 1'b0);
    p_rv = 100;
    step(1'b0, 32'h0);
    chk_b("c_req_after_redirect", imem_req_o, 1'b1);
    chk("c_addr_after_redirect", imem_addr_o, 32'h100);
    wait_valid("c_first_valid");
    chk("c_pc_first", pc_o, 32'h100);
    chk("c_instr_first", instr_o, word_of(32'h100));

    // Redirect together with a response and a pending pop, 3 buffered + 1 in flight.
    do_reset();
    lat_lo = 1; lat_hi = 1; p_rdy = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0);
    p_rv = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0);
    chk_b("d_req_at_credit_limit", imem_req_o, 1'b0);
    chk("d_pc_head", pc_o, 32'h0);
    p_rv = 100; p_rdy = 100;
    step(1'b1, 32'h200);
    chk_b("d_rvalid_in_redirect", imem_rvalid_i, 1'b1);
    chk_b("d_valid_in_redirect", instr_valid_o, 1'b0);
    chk_b("d_req_in_redirect", imem_req_o, 1'b0);
    step(1'b0, 32'h0);
    chk_b("d_valid_after_redirect", instr_valid_o, 1'b0);
    chk_b("d_req_after_redirect", imem_req_o, 1'b1);
    chk("d_addr_after_redirect", imem_addr_o, 32'h200);
    wait_valid("d_first_valid");
    chk("d_pc_first", pc_o, 32'h200);

    // Address wrap-around.
    step(1'b1, 32'hFFFF_FFF8);
    wait_valid("e_first_valid");
    chk("e_pc_0", pc_o, 32'hFFFF_FFF8);
    chk("e_pc4_0", pc_plus4_o, 32'hFFFF_FFFC);
    step(1'b0, 32'h0);
    chk_b("e_valid_1", instr_valid_o, 1'b1);
    chk("e_pc_1", pc_o, 32'hFFFF_FFFC);
    chk("e_pc4_1", pc_plus4_o, 32'h0);
    step(1'b0, 32'h0);
    chk_b("e_valid_2", instr_valid_o, 1'b1);
    chk("e_pc_2", pc_o, 32'h0);
    chk("e_instr_2", instr_o, word_of(32'h0));

    // Randomized stalls, latencies and redirects.
    p_gnt = 70; p_rv = 60; p_rdy = 70; p_redir = 2; lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 10000; k++) step(1'b0, 32'h0);
    p_redir = 0;
    for (int k = 0; k < 20; k++) step(1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
